// File: rtl/fp_normalizer_rounder.sv
// fp_normalizer_rounder
// Multi-cycle normalizer/rounder for the floating-point multiplier datapath.
// Accepts the raw significand product, the intermediate biased exponent and
// the sign. It normalizes the product with a one-bit-per-cycle left shift,
// rounds to nearest-even (or truncates), and range-checks the exponent.
// Valid/ready handshakes are used on both sides, and only one operation is
// in flight at a time.
module fp_normalizer_rounder #(
    parameter int EXP_WIDTH      = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int ROUND_EN       = 1
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        valid_in,
    output logic                        ready_out,
    input  logic                        sign_in,
    input  logic [EXP_WIDTH+1:0]        expoent_in,
    input  logic [2*MANTISSA_WIDTH+1:0] result_in,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic                        sign_out,
    output logic [EXP_WIDTH-1:0]        normal_e_out,
    output logic [MANTISSA_WIDTH:0]     normal_m_out,
    output logic                        overflow_out,
    output logic                        underflow_out,
    output logic                        inexact_out
);

    localparam int M   = MANTISSA_WIDTH;
    localparam int PW  = 2 * (M + 1);
    localparam int EW2 = EXP_WIDTH + 2;
    localparam int EW3 = EXP_WIDTH + 3;

    // Working exponent constants. The rounding exponent carries one extra
    // bit so that the carry increment can never wrap the sign.
    localparam logic signed [EW2-1:0] E_ONE  = EW2'(1);
    localparam logic signed [EW3-1:0] X_ONE  = EW3'(1);
    localparam logic signed [EW3-1:0] X_ZERO = EW3'(0);
    localparam logic signed [EW3-1:0] X_EMAX = EW3'((1 << EXP_WIDTH) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   ready_q, ready_d;
    logic [PW-1:0]          acc_q, acc_d;
    logic signed [EW2-1:0]  e_q, e_d;
    logic                   sign_q, sign_d;
    logic                   sticky_q, sticky_d;
    logic [EXP_WIDTH-1:0]   res_e_q, res_e_d;
    logic [M:0]             res_m_q, res_m_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;
    logic                   inx_q, inx_d;

    // Rounding datapath signals.
    logic [M:0]             rnd_mant;
    logic                   rnd_guard;
    logic                   rnd_sticky;
    logic                   rnd_inc;
    logic [M+1:0]           rnd_sum;
    logic signed [EW3-1:0]  rnd_e;
    logic [M:0]             rnd_m;
    logic                   rnd_inexact;

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            acc_q    <= '0;
            e_q      <= '0;
            sign_q   <= 1'b0;
            sticky_q <= 1'b0;
            res_e_q  <= '0;
            res_m_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            acc_q    <= acc_d;
            e_q      <= e_d;
            sign_q   <= sign_d;
            sticky_q <= sticky_d;
            res_e_q  <= res_e_d;
            res_m_q  <= res_m_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inx_q    <= inx_d;
        end
    end

    // Round-to-nearest-even on the normalized accumulator (bit 2M is the
    // hidden bit), including the carry-out renormalization.
    always_comb begin
        rnd_mant    = acc_q[2*M:M];
        rnd_guard   = acc_q[M-1];
        rnd_sticky  = (|acc_q[M-2:0]) | sticky_q;
        rnd_inc     = (ROUND_EN != 0) && rnd_guard && (rnd_sticky || rnd_mant[0]);
        rnd_sum     = {1'b0, rnd_mant} + {{(M+1){1'b0}}, rnd_inc};
        rnd_e       = {e_q[EW2-1], e_q};
        rnd_m       = rnd_sum[M:0];
        rnd_inexact = rnd_guard | rnd_sticky;
        if (rnd_sum[M+1]) begin
            rnd_e = rnd_e + X_ONE;
            rnd_m = {1'b1, {M{1'b0}}};
        end
    end

    // Next-state and datapath update for the IDLE/SHIFT/ROUND/DONE sequence.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        e_d      = e_q;
        sign_d   = sign_q;
        sticky_d = sticky_q;
        res_e_d  = res_e_q;
        res_m_d  = res_m_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inx_d    = inx_q;
        case (state_q)
            IDLE: begin
                if (valid_in && ready_q) begin
                    acc_d    = result_in;
                    e_d      = expoent_in;
                    sign_d   = sign_in;
                    sticky_d = 1'b0;
                    if (result_in == '0) begin
                        // Exact zero skips normalization entirely.
                        state_d = DONE;
                        res_e_d = '0;
                        res_m_d = '0;
                        ovf_d   = 1'b0;
                        unf_d   = 1'b0;
                        inx_d   = 1'b0;
                    end else if (result_in[PW-1]) begin
                        // Product in [2,4): one right shift, keep the lost bit.
                        acc_d    = result_in >> 1;
                        sticky_d = result_in[0];
                        e_d      = expoent_in + E_ONE;
                        state_d  = ROUND;
                    end else if (result_in[PW-2]) begin
                        state_d = ROUND;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_d = acc_q << 1;
                e_d   = e_q - E_ONE;
                // The bit moving into the hidden position ends the shift.
                if (acc_q[PW-3]) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                state_d = DONE;
                if (rnd_e >= X_EMAX) begin
                    ovf_d   = 1'b1;
                    unf_d   = 1'b0;
                    res_e_d = '1;
                    res_m_d = '0;
                    inx_d   = rnd_inexact;
                end else if (rnd_e <= X_ZERO) begin
                    ovf_d   = 1'b0;
                    unf_d   = 1'b1;
                    res_e_d = '0;
                    res_m_d = '0;
                    inx_d   = 1'b1;
                end else begin
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    res_e_d = rnd_e[EXP_WIDTH-1:0];
                    res_m_d = rnd_m;
                    inx_d   = rnd_inexact;
                end
            end
            DONE: begin
                if (ready_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Registered ready so it stays low for every cycle reset is sampled.
        ready_d = (state_d == IDLE);
    end

    // Outputs: result fields are only presented while the result is valid.
    always_comb begin
        valid_out     = (state_q == DONE);
        ready_out     = ready_q;
        sign_out      = 1'b0;
        normal_e_out  = '0;
        normal_m_out  = '0;
        overflow_out  = 1'b0;
        underflow_out = 1'b0;
        inexact_out   = 1'b0;
        if (state_q == DONE) begin
            sign_out      = sign_q;
            normal_e_out  = res_e_q;
            normal_m_out  = res_m_q;
            overflow_out  = ovf_q;
            underflow_out = unf_q;
            inexact_out   = inx_q;
        end
    end

endmodule

// File: tb/tb_fp_normalizer_rounder.sv
// tb_fp_normalizer_rounder
// Directed bench for fp_normalizer_rounder with its default parameters.
// The reference model computes the rounded result from the position of the
// product's leading one using plain integer arithmetic. Hand-computed
// literals pin the model for the directed vectors.
module tb_fp_normalizer_rounder;

    localparam int NQ = 64;

    logic        clk = 1'b0;
    logic        rst_n_in;
    logic        valid_in;
    logic        ready_out;
    logic        sign_in;
    logic [9:0]  expoent_in;
    logic [47:0] result_in;
    logic        valid_out;
    logic        ready_in;
    logic        sign_out;
    logic [7:0]  normal_e_out;
    logic [23:0] normal_m_out;
    logic        overflow_out;
    logic        underflow_out;
    logic        inexact_out;

    int n_cmp  = 0;
    int n_fail = 0;
    int wr_idx = 0;
    int rd_idx = 0;
    int cyc    = 0;
    logic rst_low_q = 1'b0;

    // Expected-result table written by the driver, read by the checker.
    int          q_e   [NQ];
    logic [23:0] q_m   [NQ];
    bit          q_s   [NQ];
    bit          q_ov  [NQ];
    bit          q_un  [NQ];
    bit          q_ix  [NQ];
    int          q_lat [NQ];
    int          q_cyc [NQ];
    bit          q_lit [NQ];
    int          l_e   [NQ];
    logic [23:0] l_m   [NQ];
    bit          l_ov  [NQ];
    bit          l_un  [NQ];
    bit          l_ix  [NQ];
    int          l_lat [NQ];

    fp_normalizer_rounder dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n_in),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .sign_in       (sign_in),
        .expoent_in    (expoent_in),
        .result_in     (result_in),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .sign_out      (sign_out),
        .normal_e_out  (normal_e_out),
        .normal_m_out  (normal_m_out),
        .overflow_out  (overflow_out),
        .underflow_out (underflow_out),
        .inexact_out   (inexact_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        rst_low_q <= !rst_n_in;
    end

    // Reference: locate the leading one, scale to a 24-bit significand,
    // round on the exact remainder, then range-check.
    function automatic void model(input logic [47:0] p, input int e_in,
                                  output int eo, output logic [23:0] mo,
                                  output bit ov, output bit un, output bit ix,
                                  output int lat);
        int pos;
        int e;
        longint unsigned pv, mant, rem, half;
        bit up;
        pv  = 64'(p);
        eo  = 0;
        mo  = '0;
        ov  = 1'b0;
        un  = 1'b0;
        ix  = 1'b0;
        lat = 1;
        if (pv != 0) begin
            pos = 0;
            for (int i = 0; i < 48; i++) begin
                if (p[i]) pos = i;
            end
            e   = e_in + pos - 46;
            lat = (pos >= 46) ? 2 : 48 - pos;
            if (pos >= 23) begin
                mant = pv >> (pos - 23);
                rem  = pv - (mant << (pos - 23));
                half = (pos >= 24) ? (64'd1 << (pos - 24)) : 64'd0;
            end else begin
                mant = pv << (23 - pos);
                rem  = 0;
                half = 0;
            end
            ix = (rem != 0);
            up = (rem != 0) && ((rem > half) || ((rem == half) && mant[0]));
            if (up) mant = mant + 1;
            if (mant == (64'd1 << 24)) begin
                mant = 64'd1 << 23;
                e    = e + 1;
            end
            if (e >= 255) begin
                ov = 1'b1;
                eo = 255;
            end else if (e <= 0) begin
                un = 1'b1;
                ix = 1'b1;
            end else begin
                eo = e;
                mo = mant[23:0];
            end
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Single checker: reset behaviour, output gating, result and latency.
    initial begin : cmp_proc
        int k;
        bit first;
        bit after_rst;
        first     = 1'b1;
        after_rst = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_low_q) begin
                chk("reset_outputs_zero",
                    64'({valid_out, ready_out, sign_out, normal_e_out, normal_m_out,
                         overflow_out, underflow_out, inexact_out}), 64'd0);
                rd_idx    = wr_idx;
                first     = 1'b1;
                after_rst = 1'b1;
            end else begin
                if (after_rst) begin
                    chk("ready_after_reset", 64'(ready_out), 64'd1);
                    after_rst = 1'b0;
                end
                if (valid_out) begin
                    chk("ready_low_in_done", 64'(ready_out), 64'd0);
                    if (rd_idx == wr_idx) begin
                        chk("unexpected_valid", 64'(valid_out), 64'd0);
                    end else begin
                        k = rd_idx % NQ;
                        if (first) begin
                            chk("latency", 64'(cyc - q_cyc[k]), 64'(q_lat[k]));
                            if (q_lit[k]) begin
                                chk("model_e_vs_literal",   64'(q_e[k]),   64'(l_e[k]));
                                chk("model_m_vs_literal",   64'(q_m[k]),   64'(l_m[k]));
                                chk("model_ov_vs_literal",  64'(q_ov[k]),  64'(l_ov[k]));
                                chk("model_un_vs_literal",  64'(q_un[k]),  64'(l_un[k]));
                                chk("model_ix_vs_literal",  64'(q_ix[k]),  64'(l_ix[k]));
                                chk("model_lat_vs_literal", 64'(q_lat[k]), 64'(l_lat[k]));
                            end
                            first = 1'b0;
                        end
                        chk("sign_out",      64'(sign_out),      64'(q_s[k]));
                        chk("normal_e_out",  64'(normal_e_out),  64'(q_e[k]));
                        chk("normal_m_out",  64'(normal_m_out),  64'(q_m[k]));
                        chk("overflow_out",  64'(overflow_out),  64'(q_ov[k]));
                        chk("underflow_out", 64'(underflow_out), 64'(q_un[k]));
                        chk("inexact_out",   64'(inexact_out),   64'(q_ix[k]));
                        if (ready_in) begin
                            rd_idx = rd_idx + 1;
                            first  = 1'b1;
                        end
                    end
                end else begin
                    chk("idle_outputs_zero",
                        64'({sign_out, normal_e_out, normal_m_out,
                             overflow_out, underflow_out, inexact_out}), 64'd0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (rd_idx != wr_idx && t < 400) begin
            step();
            t++;
        end
        if (rd_idx != wr_idx) begin
            $display("FAIL drain_timeout: pending=%0d required 0", wr_idx - rd_idx);
            $fatal(1, "stopping: result never delivered");
        end
    endtask

    // Present one operand, record its expectation at the accept edge.
    task automatic send(input logic [47:0] p, input int e, input logic s,
                        input bit lit, input int le, input int lm,
                        input bit lov, input bit lun, input bit lix, input int llat,
                        input bit wait_done);
        int me, mlat, k, t;
        logic [23:0] mm;
        bit mov, mun, mix;
        model(p, e, me, mm, mov, mun, mix, mlat);
        result_in  = p;
        expoent_in = 10'(e);
        sign_in    = s;
        valid_in   = 1'b1;
        t = 0;
        while (!ready_out && t < 300) begin
            step();
            t++;
        end
        if (!ready_out) begin
            $display("FAIL accept_timeout: ready_out=%0d required 1", ready_out);
            $fatal(1, "stopping: operand never accepted");
        end
        k = wr_idx % NQ;
        q_e[k]   = me;
        q_m[k]   = mm;
        q_s[k]   = s;
        q_ov[k]  = mov;
        q_un[k]  = mun;
        q_ix[k]  = mix;
        q_lat[k] = mlat;
        q_cyc[k] = cyc;
        q_lit[k] = lit;
        l_e[k]   = le;
        l_m[k]   = lm[23:0];
        l_ov[k]  = lov;
        l_un[k]  = lun;
        l_ix[k]  = lix;
        l_lat[k] = llat;
        wr_idx   = wr_idx + 1;
        step();
        valid_in = 1'b0;
        if (wait_done) wait_drain();
    endtask

    initial begin : drv_proc
        int t;
        rst_n_in   = 1'b0;
        valid_in   = 1'b0;
        ready_in   = 1'b1;
        sign_in    = 1'b0;
        expoent_in = '0;
        result_in  = '0;
        repeat (3) step();
        rst_n_in = 1'b1;
        step();

        //    product                         exp   s  lit  e    m          ov un ix lat wait
        send(48'h1 << 46,                     127, 0, 1, 127, 'h800000, 0, 0, 0, 2,  1);
        send(48'h9000_0000_0000,              127, 0, 1, 128, 'h900000, 0, 0, 0, 2,  1);
        send(48'h1 << 44,                     130, 0, 1, 128, 'h800000, 0, 0, 0, 4,  1);
        send((48'h1 << 46) | (48'h1 << 22) | 48'h1,
                                              127, 0, 1, 127, 'h800001, 0, 0, 1, 2,  1);
        send((48'h1 << 46) | (48'h1 << 22),   127, 1, 1, 127, 'h800000, 0, 0, 1, 2,  1);
        send((48'h1 << 46) | (48'h1 << 23) | (48'h1 << 22),
                                              127, 0, 1, 127, 'h800002, 0, 0, 1, 2,  1);
        send(48'h7FFF_FFFF_FFFF,              127, 0, 1, 128, 'h800000, 0, 0, 1, 2,  1);
        send(48'h1 << 47,                     254, 1, 1, 255, 'h000000, 1, 0, 0, 2,  1);
        send(48'h1 << 46,                     0,   0, 1, 0,   'h000000, 0, 1, 1, 2,  1);
        send(48'h0,                           100, 1, 1, 0,   'h000000, 0, 0, 0, 1,  1);
        send((48'h1 << 47) | (48'h1 << 23) | 48'h1,
                                              127, 1, 1, 128, 'h800001, 0, 0, 1, 2,  1);
        send(48'h1,                           200, 0, 1, 154, 'h800000, 0, 0, 0, 48, 1);
        send((48'h1 << 36) - 48'h1,           127, 0, 1, 117, 'h800000, 0, 0, 1, 13, 1);
        send(48'h1 << 40,                     6,   1, 1, 0,   'h000000, 0, 1, 1, 8,  1);

        // Backpressure: hold the result, try to sneak in an operand.
        ready_in = 1'b0;
        send(48'h9000_0000_0000,              127, 1, 1, 128, 'h900000, 0, 0, 0, 2,  0);
        t = 0;
        while (!valid_out && t < 50) begin
            step();
            t++;
        end
        if (!valid_out) begin
            $display("FAIL bp_valid_timeout: valid_out=%0d required 1", valid_out);
            $fatal(1, "stopping: no result under backpressure");
        end
        repeat (2) step();
        result_in  = 48'h1 << 45;
        expoent_in = 10'd5;
        valid_in   = 1'b1;
        repeat (2) step();
        valid_in = 1'b0;
        step();
        ready_in = 1'b1;
        wait_drain();
        send(48'h1 << 45,                     140, 0, 1, 139, 'h800000, 0, 0, 0, 3,  1);

        // Reset in the middle of a long SHIFT sequence.
        send(48'h1 << 10,                     127, 1, 0, 0,   0,        0, 0, 0, 0,  0);
        repeat (5) step();
        rst_n_in = 1'b0;
        step();
        rst_n_in = 1'b1;
        repeat (60) step();
        send(48'h1 << 46,                     127, 0, 1, 127, 'h800000, 0, 0, 0, 2,  1);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_normalizer_rounder.md
Name: fp_normalizer_rounder

Overview:
- Sequential successor to the combinational multiplier normalizer. Takes the raw 2*(MANTISSA_WIDTH+1)-bit significand product, the intermediate exponent and the sign. Produces a normalized, rounded IEEE-style result with overflow, underflow and inexact flags.
- Handles leading zeros in the product with an iterative left shift, one bit per cycle. Adds round-to-nearest-even and valid/ready handshakes on both sides.
- Sits between the mantissa multiplier and the result packer of the floating-point multiplier.

Parameters:
EXP_WIDTH, 8, biased exponent width
MANTISSA_WIDTH, 23, stored fraction width (M); output significand is M+1 bits including hidden bit
ROUND_EN, 1, 1 = round-to-nearest-even, 0 = truncate

Ports:
clk_in  input  1  clock
rst_n_in  input  1  synchronous active-low reset
valid_in  input  1  input operands valid
ready_out  output  1  block can accept operands
sign_in  input  1  product sign
expoent_in  input  EXP_WIDTH+2  signed intermediate biased exponent (ea+eb-bias), two's complement
result_in  input  2*(M+1)  unsigned significand product
valid_out  output  1  result valid
ready_in  input  1  downstream accepts result
sign_out  output  1  result sign
normal_e_out  output  EXP_WIDTH  result biased exponent
normal_m_out  output  M+1  result significand, hidden bit at MSB
overflow_out  output  1  exponent overflow, result is infinity
underflow_out  output  1  exponent underflow, result flushed to zero
inexact_out  output  1  discarded bits nonzero

Behaviour:
- Reset (rst_n_in=0 at clk edge): state IDLE; all outputs 0, including ready_out, for every cycle reset is sampled low. Reset mid-operation discards the operation and produces no valid_out.
- Internal registers: product acc[2M+1:0], signed exponent e (EXP_WIDTH+2 bits), sign.
- IDLE: ready_out=1. On valid_in & ready_out, capture the inputs. Next state depends on the captured product:
  - acc==0: DONE, with e_out=0, m_out=0, all flags 0.
  - acc[2M+1]=1: acc >>= 1, sticky-OR the shifted-out bit, e+=1, go to ROUND.
  - acc[2M]=1: go to ROUND.
  - otherwise: go to SHIFT.
- SHIFT: each cycle acc <<= 1 and e -= 1. Go to ROUND when the new acc[2M]=1. Never exceeds 2M cycles, since acc is nonzero.
- ROUND:
  - mant = acc[2M:M]; guard = acc[M-1]; sticky = |acc[M-2:0] OR the sticky from the IDLE shift.
  - inexact = guard | sticky.
  - ROUND_EN=1: mant += guard & (sticky | mant[0]). ROUND_EN=0: no increment.
  - Rounding carry out of mant: mant = 1000..0 and e += 1.
  - Range check after rounding:
    - e >= 2^EXP_WIDTH-1: overflow=1, e_out all ones, m_out=0.
    - e <= 0: underflow=1, e_out=0, m_out=0, inexact=1.
    - else: e_out=e[EXP_WIDTH-1:0], m_out=mant.
  - Go to DONE.
- DONE: valid_out=1 and outputs are stable. Outputs are held while ready_in=0. On ready_in=1, go to IDLE; valid_out falls the next cycle.
- ready_out=0 in every state except IDLE, so there is no overlap. Throughput is one operation per (latency+1) cycles minimum.
- Latency from the accept edge to valid_out high:
  - zero product: 1 cycle.
  - already normalized or MSB set: 2 cycles.
  - k leading zeros below bit 2M: 2+k cycles.
- sign_out = captured sign in all cases, including zero, overflow and underflow.
- Outputs other than valid_out are 0 outside DONE.

Test Plan:
- 1.0*1.0: result_in=1<<46, expoent_in=127, ready_in=1 -> valid_out 2 cycles after accept, e=127, m=0x800000, all flags 0.
- 1.5*1.5: result_in=0x900000000000, expoent_in=127 -> e=128, m=0x900000. Then result_in=1<<44, expoent_in=130 -> 2 SHIFT cycles, valid at cycle 4, e=128, m=0x800000.
- Rounding, ROUND_EN=1:
  - (1<<46)|(1<<22)|1 -> m=0x800001, inexact=1.
  - (1<<46)|(1<<22) (tie, lsb 0) -> m=0x800000, inexact=1.
  - (1<<46)|(1<<23)|(1<<22) -> m=0x800002.
  - All-ones result_in[46:0] with bit47=0, expoent_in=127 -> mant carries out, e=128, m=0x800000.
- Range: expoent_in=254 with bit47 set -> overflow=1, e=255, m=0. expoent_in=0 normalized -> underflow=1, e=0, m=0. result_in=0 -> e=0, m=0, no flags, valid after 1 cycle.
- Backpressure: hold ready_in=0 for 5 cycles in DONE -> valid_out and data stable, ready_out=0, and a valid_in pulse is ignored. Raising ready_in returns to IDLE and the next operand is accepted.
- Reset: assert rst_n_in=0 during SHIFT -> next cycle all outputs 0, no valid_out. After release, ready_out=1 and a fresh operation completes correctly.
